// File: rtl/sift_ori_pkg.sv
// Shared orientation-histogram definitions: bin geometry, FSM states and the
// bin-to-angle decode that inverts the direction ROM mapping.
package sift_ori_pkg;

    localparam int NUM_BINS         = 32;
    localparam int BIN_W            = 5;
    localparam int ANG_W            = 9;
    localparam int BIN_ANGLE_OFFSET = 8;

    typedef enum logic [1:0] {
        ACC,
        SCAN,
        OUT
    } state_t;

    // Bin-centre angle code: rotated bin index in the upper bits, half-bin in the low nibble.
    function automatic logic [ANG_W-1:0] bin_to_angle(input logic [BIN_W-1:0] bin);
        logic [BIN_W-1:0] centre;
        centre = bin + BIN_W'(BIN_ANGLE_OFFSET);
        return {centre, 4'b1000};
    endfunction

endpackage

// File: rtl/ori_hist_peak.sv
// 32-bin saturating orientation histogram; on end-of-window a 32-cycle scan
// finds the dominant bin (lowest index on ties) and clears the bins as it reads.
module ori_hist_peak
    import sift_ori_pkg::*;
#(
    parameter int unsigned MAG_W = 8,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BIN_W-1:0] s_bin,
    input  logic [MAG_W-1:0] s_mag,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BIN_W-1:0] m_bin,
    output logic [ANG_W-1:0] m_angle,
    output logic [ACC_W-1:0] m_peak,
    output logic             m_empty
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_bins [NUM_BINS];
    logic [BIN_W-1:0] r_idx;
    logic [BIN_W-1:0] r_max_bin;
    logic [ACC_W-1:0] r_max;
    logic [BIN_W-1:0] r_m_bin;
    logic [ANG_W-1:0] r_m_angle;
    logic [ACC_W-1:0] r_m_peak;
    logic             r_m_empty;

    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_sum_sat;
    logic [ACC_W-1:0] w_scan_val;
    logic [ACC_W-1:0] w_best_val;
    logic [BIN_W-1:0] w_best_bin;
    logic             w_scan_done;

    assign w_accept    = s_valid && s_ready;
    assign w_sum       = {1'b0, r_bins[s_bin]} + (ACC_W+1)'(s_mag);
    assign w_sum_sat   = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign w_scan_val  = r_bins[r_idx];
    assign w_scan_done = (r_idx == BIN_W'(NUM_BINS - 1));

    // Strictly-greater replace keeps the earliest (lowest-index) bin on ties.
    always_comb begin
        w_best_val = r_max;
        w_best_bin = r_max_bin;
        if (w_scan_val > r_max) begin
            w_best_val = w_scan_val;
            w_best_bin = r_idx;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            ACC: begin
                s_ready = 1'b1;
                if (s_valid && s_last) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_scan_done) w_state_nxt = OUT;
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) w_state_nxt = ACC;
            end
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACC;
        else        r_state <= w_state_nxt;
    end

    // Bins are registers, so a same-bin sample on the next cycle sees the updated sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
        end else if (w_accept) begin
            r_bins[s_bin] <= w_sum_sat;
        end else if (r_state == SCAN) begin
            r_bins[r_idx] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_max     <= '0;
            r_max_bin <= '0;
            r_m_bin   <= '0;
            r_m_angle <= '0;
            r_m_peak  <= '0;
            r_m_empty <= 1'b0;
        end else if (r_state == SCAN) begin
            r_idx     <= r_idx + BIN_W'(1);
            r_max     <= w_best_val;
            r_max_bin <= w_best_bin;
            if (w_scan_done) begin
                r_m_bin   <= w_best_bin;
                r_m_angle <= bin_to_angle(w_best_bin);
                r_m_peak  <= w_best_val;
                r_m_empty <= (w_best_val == '0);
            end
        end else begin
            r_idx     <= '0;
            r_max     <= '0;
            r_max_bin <= '0;
        end
    end

    assign m_bin   = r_m_bin;
    assign m_angle = r_m_angle;
    assign m_peak  = r_m_peak;
    assign m_empty = r_m_empty;

endmodule

// File: tb/tb_ori_hist_peak.sv
// Randomized and directed bench for ori_hist_peak against a timeline-level
// histogram model evaluated on every falling edge.
module tb_ori_hist_peak;

    localparam int MAG_W = 8;
    localparam int ACC_W = 16;
    localparam int SAT   = 65535;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       m_ready = 1'b0;
    logic [4:0] s_bin   = '0;
    logic [7:0] s_mag   = '0;
    logic       s_ready;
    logic       m_valid;
    logic       m_empty;
    logic [4:0] m_bin;
    logic [8:0] m_angle;
    logic [15:0] m_peak;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ori_hist_peak #(.MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_bin   (s_bin),
        .s_mag   (s_mag),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_bin   (m_bin),
        .m_angle (m_angle),
        .m_peak  (m_peak),
        .m_empty (m_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: window sums, then a result due 33 cycles after the last sample.
    int mb [32];
    int mode = 0;
    int cnt  = 0;
    int e_bin, e_peak, e_angle, e_empty;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mb[i] = 0;
            mode = 0;
            cnt  = 0;
            check("rst_s_ready", 32'(s_ready), 1);
            check("rst_m_valid", 32'(m_valid), 0);
            check("rst_m_bin",   32'(m_bin),   0);
            check("rst_m_angle", 32'(m_angle), 0);
            check("rst_m_peak",  32'(m_peak),  0);
            check("rst_m_empty", 32'(m_empty), 0);
        end else if (mode == 0) begin
            check("acc_s_ready", 32'(s_ready), 1);
            check("acc_m_valid", 32'(m_valid), 0);
            if (s_valid) begin
                mb[s_bin] = mb[s_bin] + int'(s_mag);
                if (mb[s_bin] > SAT) mb[s_bin] = SAT;
                if (s_last) begin
                    e_peak = 0;
                    e_bin  = 0;
                    for (int i = 0; i < 32; i++) begin
                        if (mb[i] > e_peak) begin
                            e_peak = mb[i];
                            e_bin  = i;
                        end
                    end
                    e_empty = (e_peak == 0) ? 1 : 0;
                    e_angle = ((e_bin + 8) % 32) * 16 + 8;
                    for (int i = 0; i < 32; i++) mb[i] = 0;
                    mode = 1;
                    cnt  = 0;
                end
            end
        end else begin
            cnt++;
            check("busy_s_ready", 32'(s_ready), 0);
            if (cnt < 33) begin
                check("scan_m_valid", 32'(m_valid), 0);
            end else begin
                check("out_m_valid", 32'(m_valid), 1);
                check("out_m_bin",   32'(m_bin),   32'(e_bin));
                check("out_m_angle", 32'(m_angle), 32'(e_angle));
                check("out_m_peak",  32'(m_peak),  32'(e_peak));
                check("out_m_empty", 32'(m_empty), 32'(e_empty));
                if (m_ready) mode = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input int b, input int m, input bit last);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_bin   = 5'(b);
        s_mag   = 8'(m);
        s_last  = last;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 200);
        if (!s_ready) check("send_timeout", 32'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Returns at the negedge where m_valid is first seen high.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 300);
        if (!m_valid) check("result_timeout", 32'(m_valid), 1);
    endtask

    task automatic ack(input int hold);
        @(posedge clk);
        #1;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        int len;
        int kind;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        send(24, 5, 1'b1);
        wait_result(lat);
        check("t1_latency", 32'(lat), 33);
        check("t1_m_bin",   32'(m_bin),   24);
        check("t1_m_angle", 32'(m_angle), 32'h008);
        check("t1_m_peak",  32'(m_peak),  5);
        check("t1_m_empty", 32'(m_empty), 0);
        ack(0);

        send(3, 10, 1'b0);
        send(3, 10, 1'b0);
        send(17, 19, 1'b0);
        send(17, 1, 1'b1);
        wait_result(lat);
        check("t2_m_bin",   32'(m_bin),   3);
        check("t2_m_peak",  32'(m_peak),  20);
        check("t2_m_angle", 32'(m_angle), 32'h0B8);
        ack(1);

        for (int i = 0; i < 300; i++) send(31, 255, i == 299);
        wait_result(lat);
        check("t3_m_peak",  32'(m_peak),  32'hFFFF);
        check("t3_m_bin",   32'(m_bin),   31);
        check("t3_m_angle", 32'(m_angle), 32'h078);
        ack(0);

        send(5, 0, 1'b1);
        wait_result(lat);
        check("t4_m_empty", 32'(m_empty), 1);
        check("t4_m_bin",   32'(m_bin),   0);
        check("t4_m_angle", 32'(m_angle), 32'h088);
        check("t4_m_peak",  32'(m_peak),  0);
        ack(0);

        send(12, 7, 1'b1);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_m_peak",  32'(m_peak),  7);
            check("t5_hold_s_ready", 32'(s_ready), 0);
            @(negedge clk);
        end
        check("t5_hold_m_bin", 32'(m_bin), 12);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("t5_s_ready_after", 32'(s_ready), 1);
        @(posedge clk);
        #1;
        send(9, 4, 1'b1);
        wait_result(lat);
        check("t5_m_peak", 32'(m_peak), 4);
        check("t5_m_bin",  32'(m_bin),  9);
        ack(0);

        send(20, 50, 1'b1);
        idle(12);
        rst_n = 1'b0;
        #1;
        check("t6_rst_m_valid", 32'(m_valid), 0);
        check("t6_rst_s_ready", 32'(s_ready), 1);
        check("t6_rst_m_peak",  32'(m_peak),  0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(0, 1, 1'b1);
        wait_result(lat);
        check("t6_m_bin",  32'(m_bin),  0);
        check("t6_m_peak", 32'(m_peak), 1);
        ack(0);

        for (int w = 0; w < 40; w++) begin
            len  = int'($urandom_range(1, 40));
            kind = int'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                if (kind == 0) send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), i == len - 1);
                else if (kind == 1) send(int'($urandom_range(0, 31)), 0, i == len - 1);
                else if (kind == 2) send(int'($urandom_range(0, 7)), int'($urandom % 256), i == len - 1);
                else send(int'($urandom_range(0, 31)), int'($urandom % 256), i == len - 1);
                idle(int'($urandom_range(0, 2)));
            end
            wait_result(lat);
            ack(int'($urandom_range(0, 4)));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
